w_ctrl: RTL and testbench
=========================

// Module: w_ctrl
// PURPOSE
//   Write-side pointer/flag controller of the dual-clock 256-entry FIFO; pairs with the read controller.
//   Advances a binary write address on accepted writes and drives the RAM write address and write strobe.
//   Publishes a registered Gray write pointer for the read domain.
//   Double-syncs the read-domain Gray pointer to produce full, almost-full, fill level and a sticky overflow flag.
// PARAMETERS
//   ADDR_W    8    RAM address width; pointers are ADDR_W+1 bits (extra wrap bit); depth = 2**ADDR_W
//   AFULL_TH  240  almost-full threshold in entries (1..2**ADDR_W)
// PORTS
//   w_clk       in   1         write-domain clock
//   rst_n       in   1         asynchronous active-low reset
//   w_en        in   1         write request from producer
//   w_ovf_clr   in   1         synchronous clear of w_overflow
//   r_gaddr     in   ADDR_W+1  Gray read pointer from read domain (registered there)
//   w_wr        out  1         RAM write strobe = w_en & ~w_full (combinational)
//   w_addr      out  ADDR_W    RAM write address = w_addr_bin[ADDR_W-1:0]
//   w_gaddr     out  ADDR_W+1  registered Gray write pointer to read domain
//   w_full      out  1         FIFO full, registered
//   w_afull     out  1         fill level >= AFULL_TH, registered
//   w_level     out  ADDR_W+1  registered fill-level estimate 0..2**ADDR_W
//   w_overflow  out  1         sticky: a write was attempted while full
// BEHAVIOUR
// - Reset (async, rst_n=0): w_addr_bin=0, w_gaddr=0, sync flops=0, w_full=0, w_afull=0, w_level=0, w_overflow=0.
// - Next binary pointer (comb):
//     nxt_bin = w_addr_bin + 1  if w_en & ~w_full
//     nxt_bin = w_addr_bin      otherwise
//   Modulo 2**(ADDR_W+1); wraps 511->0 at the default ADDR_W.
// - Write handshake: a write is accepted in any cycle with w_wr=1.
//   The RAM captures data at w_addr on that edge; w_addr advances on the same edge.
// - w_gaddr <= nxt_bin ^ (nxt_bin>>1) every edge, so it is in step with w_addr_bin. One bit changes per increment.
// - Read-pointer sync: r_sync1 <= r_gaddr; r_sync2 <= r_sync1 (2 w_clk stages, no logic between them).
// - Full (registered from next-state, no extra cycle of latency):
//     w_full <= (nxt_gray == {~r_sync2[ADDR_W:ADDR_W-1], r_sync2[ADDR_W-2:0]})
//   Full asserts on the edge that accepts the 2**ADDR_W-th outstanding write.
// - Level:
//     r_bin_sync = Gray-to-binary of r_sync2 (XOR prefix from MSB)
//     w_level   <= nxt_bin - r_bin_sync (ADDR_W+1 bit modulo)
//     w_afull   <= (nxt_bin - r_bin_sync) >= AFULL_TH
// - Conservatism: the read pointer is seen 2-3 w_clk cycles late.
//   w_full/w_afull may deassert late; they never deassert early. w_level never under-reports.
// - Overflow: w_en & w_full sets w_overflow next edge; the pointer does not move.
//   w_ovf_clr clears it; if set and clear occur together, set wins.
// - Simultaneous write and read-pointer advance while full: the write is rejected (full is registered).
//   Full drops once the new r_gaddr clears the sync chain.
// - Reset mid-operation: all state returns to reset values immediately.
//   Both domains must be reset together; there is no partial-reset recovery.
// TESTING
// - Reset, then w_en=1 for 256 cycles with r_gaddr=0 ->
//   w_addr 0..255, w_full=1 after 256th accept, w_level=256, w_gaddr=9'h180.
// - Full with w_en=1 for 3 more cycles ->
//   w_wr=0, w_addr holds 0, w_overflow=1. Pulse w_ovf_clr -> w_overflow=0 next edge.
// - From full, set r_gaddr=9'h001 (one read) ->
//   w_full falls 3 edges later, w_level=255, next write accepted at w_addr=0.
// - Stream 300 writes against a reader that keeps pace ->
//   w_addr_bin wraps 511->0 with no false full; every w_gaddr step changes exactly one bit.
// - Fill to 239 then 240 entries with r_gaddr=0 ->
//   w_afull=0 at 239, w_afull=1 on the edge accepting the 240th write.
// - Assert rst_n=0 mid-burst at level 100 ->
//   all outputs 0 asynchronously; after release, the first write goes to w_addr=0.

Source files
------------

// File: rtl/w_ctrl.sv
// w_ctrl: write-side pointer and flag controller for a dual-clock FIFO.
//   Keeps a binary write pointer with an extra wrap bit and advances it on
//   every accepted write. It drives the RAM write address and write strobe,
//   and publishes a registered Gray write pointer for the read domain.
//   The Gray read pointer from the read domain is passed through two
//   synchronizer flops. From it the block derives full, almost-full, the
//   fill level and a sticky overflow flag.
// Ports:
//   w_clk       write-domain clock
//   rst_n       asynchronous active-low reset
//   w_en        write request
//   w_ovf_clr   synchronous clear of w_overflow
//   r_gaddr     Gray read pointer from the read domain
//   w_wr        RAM write strobe (combinational, w_en & ~w_full)
//   w_addr      RAM write address
//   w_gaddr     registered Gray write pointer
//   w_full      registered full flag
//   w_afull     registered almost-full flag (level >= AFULL_TH)
//   w_level     registered fill level, 0..2**ADDR_W
//   w_overflow  sticky flag: a write was attempted while full
module w_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int AFULL_TH = 240
) (
  input  logic              w_clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic              w_ovf_clr,
  input  logic [ADDR_W:0]   r_gaddr,
  output logic              w_wr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_gaddr,
  output logic              w_full,
  output logic              w_afull,
  output logic [ADDR_W:0]   w_level,
  output logic              w_overflow
);

  localparam logic [ADDR_W:0] AFULL_V = (ADDR_W+1)'(AFULL_TH);

  logic [ADDR_W:0] w_addr_bin;
  logic [ADDR_W:0] nxt_bin;
  logic [ADDR_W:0] nxt_gray;
  logic [ADDR_W:0] r_sync1;
  logic [ADDR_W:0] r_sync2;
  logic [ADDR_W:0] r_bin_sync;
  logic [ADDR_W:0] full_cmp;
  logic [ADDR_W:0] level_nxt;

  assign w_wr   = w_en & ~w_full;
  assign w_addr = w_addr_bin[ADDR_W-1:0];

  always_comb begin
    nxt_bin  = w_addr_bin + {{ADDR_W{1'b0}}, w_wr};
    nxt_gray = nxt_bin ^ (nxt_bin >> 1);
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    r_bin_sync = '0;
    for (int unsigned i = 0; i <= ADDR_W; i++) begin
      r_bin_sync[i] = ^(r_sync2 >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer once. In Gray
  // code that means the two top bits are inverted and all others are equal.
  assign full_cmp  = {~r_sync2[ADDR_W -: 2], r_sync2[ADDR_W-2:0]};
  assign level_nxt = nxt_bin - r_bin_sync;

  always_ff @(posedge w_clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr_bin <= '0;
      w_gaddr    <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      w_full     <= 1'b0;
      w_afull    <= 1'b0;
      w_level    <= '0;
      w_overflow <= 1'b0;
    end else begin
      w_addr_bin <= nxt_bin;
      w_gaddr    <= nxt_gray;
      r_sync1    <= r_gaddr;
      r_sync2    <= r_sync1;
      // Flags are computed from the next-state pointer. This lets full rise
      // on the same edge that accepts the last free entry.
      w_full     <= (nxt_gray == full_cmp);
      w_level    <= level_nxt;
      w_afull    <= (level_nxt >= AFULL_V);
      // If set and clear occur in the same cycle, set wins.
      w_overflow <= (w_en & w_full) | (w_overflow & ~w_ovf_clr);
    end
  end

endmodule

// File: tb/tb_w_ctrl.sv
module tb_w_ctrl;

  logic       w_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic       w_ovf_clr = 1'b0;
  logic [8:0] r_gaddr = '0;
  logic       w_wr;
  logic [7:0] w_addr;
  logic [8:0] w_gaddr;
  logic       w_full;
  logic       w_afull;
  logic [8:0] w_level;
  logic       w_overflow;

  w_ctrl #(.ADDR_W(8), .AFULL_TH(240)) dut (
    .w_clk(w_clk), .rst_n(rst_n), .w_en(w_en), .w_ovf_clr(w_ovf_clr),
    .r_gaddr(r_gaddr), .w_wr(w_wr), .w_addr(w_addr), .w_gaddr(w_gaddr),
    .w_full(w_full), .w_afull(w_afull), .w_level(w_level),
    .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  // Signal selectors for expectations
  localparam int S_WR = 0, S_ADDR = 1, S_GADDR = 2, S_FULL = 3, S_AFULL = 4,
                 S_LEVEL = 5, S_OVF = 6, S_GSTEP = 7;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [8:0] last_g = '0;

  initial forever begin
    @(posedge w_clk);
    cyc++;
  end

  function automatic logic [8:0] g(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int actual(input int sel);
    case (sel)
      S_WR:    return int'(w_wr);
      S_ADDR:  return int'(w_addr);
      S_GADDR: return int'(w_gaddr);
      S_FULL:  return int'(w_full);
      S_AFULL: return int'(w_afull);
      S_LEVEL: return int'(w_level);
      S_OVF:   return int'(w_overflow);
      default: return $countones(w_gaddr ^ last_g);
    endcase
  endfunction

  // Monitor: samples on the falling edge and retires the expectations
  // tagged for the current cycle.
  initial forever begin
    @(negedge w_clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      int   a;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.nm, e.cyc, cyc);
      end else begin
        a = actual(e.sel);
        if (a != e.val) begin
          failures++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d", e.nm, cyc, a, e.val);
        end
      end
    end
    last_g = w_gaddr;
  end

  task automatic ex(input int sel, input int val, input string nm);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.val = val; e.nm = nm;
    q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge. Expectations pushed
  // afterwards are checked at this cycle's falling edge.
  task automatic step(input logic rst, input logic en, input logic clr, input logic [8:0] r);
    @(posedge w_clk);
    #1;
    rst_n = ~rst; w_en = en; w_ovf_clr = clr; r_gaddr = r;
  endtask

  task automatic ex_zero(input string nm);
    ex(S_WR, 0, {nm, "_wr"});     ex(S_ADDR, 0, {nm, "_addr"});
    ex(S_GADDR, 0, {nm, "_gaddr"}); ex(S_FULL, 0, {nm, "_full"});
    ex(S_AFULL, 0, {nm, "_afull"}); ex(S_LEVEL, 0, {nm, "_level"});
    ex(S_OVF, 0, {nm, "_ovf"});
  endtask

  initial begin
    logic [8:0] wp;
    #12 rst_n = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 9'd0);
    ex_zero("reset");

    // Fill 256 entries with the reader idle; includes the afull threshold
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 1'b0, 9'd0);
      ex(S_WR, 1, "fill_wr");
      ex(S_ADDR, i, "fill_addr");
      ex(S_LEVEL, i, "fill_level");
      ex(S_GADDR, int'(g(9'(i))), "fill_gaddr");
      ex(S_FULL, 0, "fill_full");
      ex(S_AFULL, (i >= 240) ? 1 : 0, "fill_afull");
    end

    // Full: writes rejected, overflow set, pointer held
    step(1'b0, 1'b1, 1'b0, 9'd0);
    ex(S_FULL, 1, "full_flag"); ex(S_LEVEL, 256, "full_level");
    ex(S_GADDR, 'h180, "full_gaddr"); ex(S_WR, 0, "full_wr");
    ex(S_ADDR, 0, "full_addr"); ex(S_OVF, 0, "ovf_not_yet");
    step(1'b0, 1'b1, 1'b0, 9'd0);
    ex(S_OVF, 1, "ovf_set"); ex(S_WR, 0, "full_wr2"); ex(S_ADDR, 0, "full_addr2");
    step(1'b0, 1'b1, 1'b0, 9'd0);
    ex(S_OVF, 1, "ovf_sticky"); ex(S_LEVEL, 256, "full_level2");
    step(1'b0, 1'b0, 1'b1, 9'd0);
    ex(S_OVF, 1, "ovf_before_clr");
    step(1'b0, 1'b1, 1'b1, 9'd0);
    ex(S_OVF, 0, "ovf_cleared");
    step(1'b0, 1'b0, 1'b1, 9'd0);
    ex(S_OVF, 1, "ovf_set_wins");
    step(1'b0, 1'b0, 1'b0, 9'd0);
    ex(S_OVF, 0, "ovf_cleared2");

    // One read: full falls on the third edge after r_gaddr changes
    step(1'b0, 1'b0, 1'b0, 9'h001);
    ex(S_FULL, 1, "rd_full_e0");
    step(1'b0, 1'b0, 1'b0, 9'h001);
    ex(S_FULL, 1, "rd_full_e1");
    step(1'b0, 1'b0, 1'b0, 9'h001);
    ex(S_FULL, 1, "rd_full_e2");
    step(1'b0, 1'b1, 1'b0, 9'h001);
    ex(S_FULL, 0, "rd_full_drop"); ex(S_LEVEL, 255, "rd_level");
    ex(S_WR, 1, "rd_wr"); ex(S_ADDR, 0, "rd_addr");
    step(1'b0, 1'b0, 1'b0, 9'h001);
    ex(S_FULL, 1, "refull"); ex(S_LEVEL, 256, "refull_level");
    ex(S_GADDR, 'h181, "refull_gaddr");

    // Reader jumps ahead to leave 4 entries, then keeps pace over a wrap
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, g(9'd253));
    ex(S_FULL, 0, "drain_full"); ex(S_LEVEL, 4, "drain_level");
    wp = 9'd257;
    for (int k = 0; k < 300; k++) begin
      step(1'b0, 1'b1, 1'b0, g(wp - 9'd3));
      ex(S_WR, 1, "strm_wr");
      ex(S_ADDR, int'(wp[7:0]), "strm_addr");
      ex(S_GADDR, int'(g(wp)), "strm_gaddr");
      ex(S_FULL, 0, "strm_full");
      if (k > 0) ex(S_GSTEP, 1, "strm_gray_step");
      wp = wp + 9'd1;
    end

    // Reset, refill to 100, then reset mid-burst
    step(1'b1, 1'b0, 1'b0, 9'd0);
    ex_zero("reset2");
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0, 9'd0);
      ex(S_ADDR, i, "burst_addr");
    end
    step(1'b0, 1'b1, 1'b0, 9'd0);
    ex(S_LEVEL, 100, "burst_level");
    step(1'b1, 1'b0, 1'b0, 9'd0);
    ex_zero("midrst");
    step(1'b0, 1'b1, 1'b0, 9'd0);
    ex(S_ADDR, 0, "post_rst_addr"); ex(S_WR, 1, "post_rst_wr");
    step(1'b0, 1'b0, 1'b0, 9'd0);
    ex(S_ADDR, 1, "post_rst_addr2"); ex(S_LEVEL, 1, "post_rst_level");

    repeat (2) @(negedge w_clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
